// File: rtl/entrada_time_ctrl.sv
// Time-entry controller: debounced-edge mode/inc buttons drive a RUN/SET_H/SET_M/SET_S
// FSM with idle timeout. Define ENTRADA_TIME_AUTO_REPEAT_EN to enable auto-repeat on a held inc.
module entrada_time_ctrl #(
  parameter int TIMEOUT      = 50,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       Hz,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       inc,
  output logic       sel,
  output logic       Q_h,
  output logic       Q_m,
  output logic       Q_s,
  output logic [1:0] field
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [2:0]    mode_sh;
  logic [2:0]    inc_sh;
  logic [1:0]    warm;
  logic          mode_armed;
  logic          inc_armed;
  logic          mode_edge;
  logic          inc_edge;
  logic          rep_pulse;
  logic          inc_fire;

  // [0],[1] synchronize, [2] is the previous synchronized value. A button only becomes
  // armed once it has been seen low after the synchronizer has refilled out of reset,
  // so a button held across reset release never yields an edge.
  always_ff @(posedge Hz or negedge rst_n) begin
    if (!rst_n) begin
      mode_sh    <= '0;
      inc_sh     <= '0;
      warm       <= '0;
      mode_armed <= 1'b0;
      inc_armed  <= 1'b0;
    end else begin
      mode_sh    <= {mode_sh[1:0], mode};
      inc_sh     <= {inc_sh[1:0], inc};
      warm       <= {warm[0], 1'b1};
      mode_armed <= mode_armed | (warm[1] & ~mode_sh[1]);
      inc_armed  <= inc_armed | (warm[1] & ~inc_sh[1]);
    end
  end

  assign mode_edge = mode_sh[1] & ~mode_sh[2] & mode_armed;
  assign inc_edge  = inc_sh[1] & ~inc_sh[2] & inc_armed;
  assign inc_fire  = inc_edge | rep_pulse;

`ifdef ENTRADA_TIME_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rcnt;
  logic [RW-1:0] rep_target;
  logic          rep_on;
  logic          rep_fast;

  // First repeat waits REPEAT_DELAY after the initial pulse, later ones REPEAT_RATE apart.
  assign rep_target = rep_fast ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
  assign rep_pulse  = rep_on & inc_sh[1] & (rcnt == rep_target);

  always_ff @(posedge Hz or negedge rst_n) begin
    if (!rst_n) begin
      rcnt     <= '0;
      rep_on   <= 1'b0;
      rep_fast <= 1'b0;
    end else if (mode_edge || !inc_sh[1] || state == RUN) begin
      rcnt     <= '0;
      rep_on   <= 1'b0;
      rep_fast <= 1'b0;
    end else if (inc_edge) begin
      rcnt     <= '0;
      rep_on   <= 1'b1;
      rep_fast <= 1'b0;
    end else if (rep_pulse) begin
      rcnt     <= '0;
      rep_fast <= 1'b1;
    end else if (rep_on) begin
      rcnt <= rcnt + RW'(1);
    end
  end
`else
  // Repeat timing is inert without auto-repeat; this folds to a constant 0.
  assign rep_pulse = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

  function automatic state_t next_state(input state_t s);
    case (s)
      RUN:     next_state = SET_H;
      SET_H:   next_state = SET_M;
      SET_M:   next_state = SET_S;
      default: next_state = RUN;
    endcase
  endfunction

  // Priority: mode edge, then inc/repeat pulse, then timeout. An inc edge coinciding
  // with a mode edge is dropped; a Q pulse already registered finishes on its own.
  always_ff @(posedge Hz or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      sel   <= 1'b0;
      Q_h   <= 1'b0;
      Q_m   <= 1'b0;
      Q_s   <= 1'b0;
      tcnt  <= '0;
    end else begin
      Q_h <= 1'b0;
      Q_m <= 1'b0;
      Q_s <= 1'b0;
      if (mode_edge) begin
        state <= next_state(state);
        sel   <= (state != SET_S);
        tcnt  <= '0;
      end else if (state == RUN) begin
        tcnt <= '0;
      end else if (inc_fire) begin
        Q_h  <= (state == SET_H);
        Q_m  <= (state == SET_M);
        Q_s  <= (state == SET_S);
        tcnt <= '0;
      end else if (tcnt == T_LAST) begin
        state <= RUN;
        sel   <= 1'b0;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  assign field = state;

endmodule

// File: tb/tb_entrada_time_ctrl.sv
// Bench for entrada_time_ctrl: directed and random button presses checked cycle by cycle
// against an event-level model of field, sel and the Q pulses, followed by reset scenarios.
module tb_entrada_time_ctrl;

  localparam int TIMEOUT = 20;
  localparam int RDELAY  = 8;
  localparam int RRATE   = 4;
  localparam int LOG_N   = 8192;

  logic       Hz = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode = 1'b0;
  logic       inc = 1'b0;
  logic       sel;
  logic       Q_h;
  logic       Q_m;
  logic       Q_s;
  logic [1:0] field;

  entrada_time_ctrl #(
    .TIMEOUT(TIMEOUT),
    .REPEAT_DELAY(RDELAY),
    .REPEAT_RATE(RRATE)
  ) dut (
    .Hz(Hz),
    .rst_n(rst_n),
    .mode(mode),
    .inc(inc),
    .sel(sel),
    .Q_h(Q_h),
    .Q_m(Q_m),
    .Q_s(Q_s),
    .field(field)
  );

  // clock / cycle count / observation log
  always #5 Hz = ~Hz;

  int cyc = 0;
  always @(posedge Hz) cyc <= cyc + 1;

  bit         log_en = 1'b1;
  logic [1:0] act_field [LOG_N];
  logic       act_sel   [LOG_N];
  logic [2:0] act_q     [LOG_N];

  always @(negedge Hz) begin
    if (log_en && cyc < LOG_N) begin
      act_field[cyc] <= field;
      act_sel[cyc]   <= sel;
      act_q[cyc]     <= {Q_h, Q_m, Q_s};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event-level reference: field advances by one per mode press (mod 4), an inc press in a
  // SET field emits a one-hot pulse for that field, and a SET field falls back to RUN
  // TIMEOUT cycles after its last event unless a new event lands on or before that cycle.
  int         m_field = 0;
  int         m_last = 0;
  int         fill_ptr = 0;
  logic [1:0] exp_field [LOG_N];
  logic [2:0] exp_q     [LOG_N];

  function automatic void model_fill(input int upto);
    for (int k = fill_ptr; k < upto; k++) begin
      if (m_field != 0 && k >= m_last + TIMEOUT) m_field = 0;
      exp_field[k] = 2'(m_field);
      exp_q[k]     = 3'b000;
    end
    if (upto > fill_ptr) fill_ptr = upto;
  endfunction

  function automatic logic [2:0] model_event(input int r, input bit is_mode, input bit is_inc);
    logic [2:0] q;
    model_fill(r);
    q = 3'b000;
    if (is_mode) begin
      m_field = (m_field + 1) % 4;
      m_last  = r;
    end else if (is_inc && m_field != 0) begin
      q      = 3'b100 >> (m_field - 1);
      m_last = r;
    end
    exp_field[r] = 2'(m_field);
    exp_q[r]     = q;
    fill_ptr     = r + 1;
    return q;
  endfunction

  // driver tasks
  task automatic pulse_btn(input bit m, input bit i, input int hold, output int start);
    @(posedge Hz);
    #1;
    start = cyc;
    mode  = m;
    inc   = i;
    repeat (hold) @(posedge Hz);
    #1;
    mode = 1'b0;
    inc  = 1'b0;
  endtask

  // The press is first sampled on edge start+1 and takes effect on edge start+3.
  task automatic press(input bit m, input bit i, input int hold, input int gap, output int r);
    int s;
`ifdef ENTRADA_TIME_AUTO_REPEAT_EN
    logic [2:0] q;
`endif
    pulse_btn(m, i, hold, s);
    r = s + 3;
`ifdef ENTRADA_TIME_AUTO_REPEAT_EN
    q = model_event(r, m, i);
    if (!m && q != 3'b000)
      for (int o = RDELAY; o <= hold - 1; o += RRATE) void'(model_event(r + o, 1'b0, 1'b1));
`else
    void'(model_event(r, m, i));
`endif
    repeat (gap) @(posedge Hz);
  endtask

  task automatic goto_field(input int target);
    int r;
    model_fill(cyc + 1);
    for (int n = 0; n < 8 && m_field != target; n++) begin
      press(1'b1, 1'b0, 2, 2, r);
      model_fill(cyc + 1);
    end
  endtask

  initial begin
    int r, r1, r2, s, n, cnt, exp_cnt, qcnt, fcnt, kind;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge Hz);
    #1;
    check("rst_field", 8'(field), 8'd0);
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_q", 8'({Q_h, Q_m, Q_s}), 8'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge Hz);

    // mode held 5 cycles enters SET_H on the 3rd edge
    goto_field(0);
    press(1'b1, 1'b0, 5, 4, r);
    check("enter_before", 8'(act_field[r-1]), 8'd0);
    check("enter_field", 8'(act_field[r]), 8'd1);
    check("enter_sel", 8'(act_sel[r]), 8'd1);
    check("enter_q", 8'(act_q[r]), 8'd0);

    // inc in SET_M pulses Q_m once; inc in RUN does nothing
    goto_field(2);
    press(1'b0, 1'b1, 2, 4, r);
    check("setm_q", 8'(act_q[r]), 8'b010);
    check("setm_q_next", 8'(act_q[r+1]), 8'd0);
    goto_field(0);
    press(1'b0, 1'b1, 2, 4, r);
    check("run_inc_q", 8'(act_q[r]), 8'd0);
    check("run_inc_q_next", 8'(act_q[r+1]), 8'd0);

    // four mode presses walk the full ring
    for (int p = 1; p <= 4; p++) begin
      press(1'b1, 1'b0, 2, 3, r);
      check($sformatf("ring_field%0d", p), 8'(act_field[r]), 8'(p % 4));
      check($sformatf("ring_sel%0d", p), 8'(act_sel[r]), 8'(p % 4 != 0));
    end

    // idle timeout, then timeout restarted by an inc 15 cycles after entry
    goto_field(0);
    press(1'b1, 1'b0, 2, 30, r);
    check("to_hold", 8'(act_field[r+TIMEOUT-1]), 8'd1);
    check("to_run", 8'(act_field[r+TIMEOUT]), 8'd0);
    check("to_sel", 8'(act_sel[r+TIMEOUT]), 8'd0);
    goto_field(0);
    press(1'b1, 1'b0, 2, 12, r1);
    press(1'b0, 1'b1, 2, 30, r2);
    check("to_inc_gap", 8'(r2 - r1), 8'd15);
    check("to_inc_old", 8'(act_field[r1+TIMEOUT]), 8'd1);
    check("to_inc_hold", 8'(act_field[r2+TIMEOUT-1]), 8'd1);
    check("to_inc_run", 8'(act_field[r2+TIMEOUT]), 8'd0);

    // mode and inc together in SET_S: mode wins, inc dropped
    goto_field(3);
    press(1'b1, 1'b1, 2, 4, r);
    check("both_field", 8'(act_field[r]), 8'd0);
    check("both_q", 8'(act_q[r]) | 8'(act_q[r+1]), 8'd0);

    // inc held 30 cycles in SET_H
    goto_field(1);
    press(1'b0, 1'b1, 30, 40, r);
    cnt = 0;
    for (int k = r; k < r + 34; k++) if (act_q[k][2]) cnt++;
`ifdef ENTRADA_TIME_AUTO_REPEAT_EN
    exp_cnt = 2 + (30 - 1 - RDELAY) / RRATE;
`else
    exp_cnt = 1;
`endif
    check("hold_pulses", 8'(cnt), 8'(exp_cnt));

    // random presses
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4)      press(1'b1, 1'b0, $urandom_range(1, 6), $urandom_range(2, 26), r);
      else if (kind < 9) press(1'b0, 1'b1, $urandom_range(1, 6), $urandom_range(2, 26), r);
      else               press(1'b1, 1'b1, $urandom_range(1, 6), $urandom_range(2, 26), r);
    end

    // cycle-by-cycle comparison of the whole log
    repeat (30) @(posedge Hz);
    @(negedge Hz);
    #1;
    n = cyc;
    if (n >= LOG_N) n = LOG_N - 1;
    model_fill(n + 1);
    for (int k = 1; k <= n; k++) begin
      check($sformatf("field[%0d]", k), 8'(act_field[k]), 8'(exp_field[k]));
      check($sformatf("sel[%0d]", k), 8'(act_sel[k]), 8'(exp_field[k] != 2'd0));
      check($sformatf("q[%0d]", k), 8'(act_q[k]), 8'(exp_q[k]));
    end
    log_en = 1'b0;

    // reset asserted while a Q_h pulse is live
    rst_n = 1'b0;
    repeat (2) @(posedge Hz);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge Hz);
    pulse_btn(1'b1, 1'b0, 2, s);
    @(posedge Hz);
    #1;
    check("mid_enter", 8'(field), 8'd1);
    pulse_btn(1'b0, 1'b1, 2, s);
    @(posedge Hz);
    #1;
    check("mid_qh", 8'(Q_h), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", 8'({Q_h, Q_m, Q_s}), 8'd0);
    check("mid_rst_field", 8'(field), 8'd0);
    check("mid_rst_sel", 8'(sel), 8'd0);
    repeat (2) @(posedge Hz);
    #1;
    rst_n = 1'b1;
    qcnt = 0;
    fcnt = 0;
    repeat (12) begin
      @(negedge Hz);
      if (Q_h || Q_m || Q_s) qcnt++;
      if (field != 2'd0) fcnt++;
    end
    check("after_rst_q", 8'(qcnt), 8'd0);
    check("after_rst_field", 8'(fcnt), 8'd0);

    // buttons held across reset release produce no edge
    @(posedge Hz);
    #1;
    mode  = 1'b1;
    inc   = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge Hz);
    #1;
    rst_n = 1'b1;
    qcnt = 0;
    fcnt = 0;
    repeat (10) begin
      @(negedge Hz);
      if (Q_h || Q_m || Q_s) qcnt++;
      if (field != 2'd0) fcnt++;
    end
    check("held_q", 8'(qcnt), 8'd0);
    check("held_field", 8'(fcnt), 8'd0);
    #1;
    mode = 1'b0;
    inc  = 1'b0;
    repeat (3) @(posedge Hz);
    pulse_btn(1'b1, 1'b0, 2, s);
    @(posedge Hz);
    #1;
    check("rearm_field", 8'(field), 8'd1);
    check("rearm_sel", 8'(sel), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
